// File: rtl/cpu_if.sv
// Instruction fetch stage: keeps the fetch PC, issues single-outstanding word reads and
// presents the fetched instruction to IF/ID through a valid/stall handshake.
module cpu_if #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ready,
  input  logic        ibus_valid,
  input  logic [31:0] ibus_rdata,
  output logic        inst_valid,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        addr_err
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q;
  logic        unaligned;
  logic        transfer;

  assign unaligned = (fetch_pc_q[1:0] != 2'b00);
  assign transfer  = inst_valid && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StReq;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect) begin
      // ibus_req is masked during redirect, so only an accepted-but-unanswered read is in flight
      state_d = (state_q == StWait && !ibus_valid) ? StDrop : StReq;
    end else begin
      unique case (state_q)
        StReq: begin
          if (unaligned) begin
            state_d = StHold;
          end else if (ibus_ready) begin
            state_d = StWait;
          end
        end
        StWait: if (ibus_valid) state_d = StHold;
        StHold: if (transfer) state_d = StReq;
        StDrop: if (ibus_valid) state_d = StReq;
        default: state_d = StReq;
      endcase
    end
  end

  always_comb begin
    ibus_req  = (state_q == StReq) && !unaligned && !redirect && !rst;
    ibus_addr = fetch_pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      inst_valid <= 1'b0;
      pc_o       <= RESET_PC;
      inst_o     <= 32'h0;
      addr_err   <= 1'b0;
    end else if (redirect) begin
      fetch_pc_q <= redirect_pc;
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      unique case (state_q)
        StReq: begin
          if (unaligned) begin
            inst_valid <= 1'b1;
            addr_err   <= 1'b1;
            inst_o     <= 32'h0;
            pc_o       <= fetch_pc_q;
          end
        end
        StWait: begin
          if (ibus_valid) begin
            inst_valid <= 1'b1;
            addr_err   <= 1'b0;
            inst_o     <= ibus_rdata;
            pc_o       <= fetch_pc_q;
          end
        end
        StHold: begin
          if (transfer) begin
            inst_valid <= 1'b0;
            fetch_pc_q <= fetch_pc_q + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
